// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM; optional counters under PERF_COUNT_EN
module instr_sequencer #(
    parameter int              IW          = 9,
    parameter int              MEM_TIMEOUT = 15,
    parameter logic [IW-1:0]   HALT_CODE   = 9'h1FF
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [IW-1:0] instr_in,
    input  logic          imem_valid,
    output logic          imem_req,
    input  logic          br_taken,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic [IW-1:0] mach_code,
    output logic          RegDst,
    output logic          MemtoReg,
    output logic          MemWrite,
    output logic          Branch,
    output logic          reg_we,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          busy,
    output logic          halted,
    output logic          err,
    output logic [15:0]   cyc_cnt,
    output logic [15:0]   instr_cnt
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   ir;
    logic [TW-1:0]   timer;
    logic            ctl_en;
    logic            in_wb;
    logic [2:0]      op;
    logic            is_load;
    logic            is_store;
    logic            is_branch;

    assign op        = ir[IW-1 -: 3];
    assign is_load   = (op == 3'b101);
    assign is_store  = (op == 3'b110);
    assign is_branch = (op == 3'b111);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_FETCH;
            S_FETCH:  if (imem_valid) state_n = S_DECODE;
            S_DECODE: state_n = (ir == HALT_CODE) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_load || is_store) state_n = S_MEM;
                else if (is_branch)      state_n = S_FETCH;
                else                     state_n = S_WB;
            end
            S_MEM: begin
                // An ack arriving on the final allowed cycle still completes the access.
                if (mem_ack)                  state_n = is_load ? S_WB : S_FETCH;
                else if (timer == TIMER_LAST) state_n = S_ERR;
            end
            S_WB:     state_n = S_FETCH;
            default:  state_n = state;
        endcase
    end

    // Status outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            ir       <= '0;
            timer    <= '0;
            imem_req <= 1'b0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
            ctl_en   <= 1'b0;
            in_wb    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_FETCH && imem_valid) ir <= instr_in;
            timer    <= (state == S_MEM) ? timer + 1'b1 : '0;
            imem_req <= (state_n == S_FETCH);
            mem_req  <= (state_n == S_MEM);
            busy     <= (state_n != S_IDLE) && (state_n != S_HALT) && (state_n != S_ERR);
            halted   <= (state_n == S_HALT);
            err      <= (state_n == S_ERR);
            ctl_en   <= (state_n == S_DECODE) || (state_n == S_EXEC) ||
                        (state_n == S_MEM)    || (state_n == S_WB);
            in_wb    <= (state_n == S_WB);
        end
    end

    assign mach_code = ir;
    assign RegDst    = ctl_en & (op != 3'b100);
    assign MemtoReg  = ctl_en & is_load;
    assign MemWrite  = ctl_en & is_store;
    assign Branch    = ctl_en & is_branch;

    assign reg_we  = in_wb;
    assign pc_load = (state == S_EXEC) & is_branch & br_taken;
    assign pc_inc  = in_wb
                   | ((state == S_EXEC) & is_branch & ~br_taken)
                   | ((state == S_MEM)  & is_store  & mem_ack);

`ifdef PERF_COUNT_EN
    logic [15:0] cyc_q;
    logic [15:0] instr_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_q   <= '0;
            instr_q <= '0;
        end else begin
            if (busy && cyc_q != 16'hFFFF)                  cyc_q   <= cyc_q + 16'd1;
            if ((pc_inc || pc_load) && instr_q != 16'hFFFF) instr_q <= instr_q + 16'd1;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instr_cnt = instr_q;
`else
    assign cyc_cnt   = 16'd0;
    assign instr_cnt = 16'd0;
`endif

endmodule
